// File: rtl/chess_clock_ctrl_pkg.sv
// Shared types for the chess game-clock controller: players, game results
// and the controller's FSM states.
package chess_clock_ctrl_pkg;

  typedef enum logic {
    WHITE = 1'b0,
    BLACK = 1'b1
  } player_t;

  typedef enum logic [1:0] {
    RES_NONE       = 2'd0,
    RES_WHITE_WINS = 2'd1,
    RES_BLACK_WINS = 2'd2
  } result_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    WHITE_RUN,
    BLACK_RUN,
    GAME_OVER
  } clk_state_t;

  localparam int MOVE_CNT_W = 10;

endpackage

// File: rtl/chess_clock_ctrl.sv
// Game-clock controller: loads both player timers at game start, enables the
// timer of the side to move, debounces move pulses with a holdoff window and
// reports flag-fall / resignation results with a full-move count.
module chess_clock_ctrl
  import chess_clock_ctrl_pkg::*;
#(
  parameter int MOVE_HOLDOFF = 4,
  parameter int MAX_MOVES    = 999
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  game_start,
  input  logic                  move_done,
  input  logic                  resign,
  input  logic                  white_time_up,
  input  logic                  black_time_up,
  output logic                  timer_load,
  output logic                  white_run,
  output logic                  black_run,
  output player_t               side_to_move,
  output logic                  game_over,
  output result_t               result,
  output logic [MOVE_CNT_W-1:0] move_count
);

  // A zero holdoff still needs a 1-bit counter that simply never leaves 0.
  localparam int HOLD_W = (MOVE_HOLDOFF > 0) ? $clog2(MOVE_HOLDOFF + 1) : 1;
  localparam logic [HOLD_W-1:0]     HOLD_LOAD = HOLD_W'(MOVE_HOLDOFF);
  localparam logic [MOVE_CNT_W-1:0] MOVE_MAX  = MOVE_CNT_W'(MAX_MOVES);

  clk_state_t              state_q, state_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  player_t                 side_d;
  result_t                 result_d;
  logic [MOVE_CNT_W-1:0]   count_d;
  logic                    move_ok;

  // Next-state, game bookkeeping and holdoff counter update.
  always_comb begin
    state_d  = state_q;
    side_d   = side_to_move;
    result_d = result;
    count_d  = move_count;
    hold_d   = (hold_q != '0) ? hold_q - HOLD_W'(1) : hold_q;
    move_ok  = move_done && (hold_q == '0);
    unique case (state_q)
      IDLE, GAME_OVER: begin
        // New game state is set on entry to LOAD so it is visible alongside timer_load.
        if (game_start) begin
          state_d  = LOAD;
          side_d   = WHITE;
          result_d = RES_NONE;
          count_d  = '0;
        end
      end
      LOAD: state_d = ARM;
      ARM:  state_d = WHITE_RUN;
      WHITE_RUN: begin
        if (white_time_up || resign) begin
          state_d  = GAME_OVER;
          result_d = RES_BLACK_WINS;
        end else if (move_ok) begin
          state_d = BLACK_RUN;
          side_d  = BLACK;
          hold_d  = HOLD_LOAD;
        end
      end
      BLACK_RUN: begin
        if (black_time_up || resign) begin
          state_d  = GAME_OVER;
          result_d = RES_WHITE_WINS;
        end else if (move_ok) begin
          state_d = WHITE_RUN;
          side_d  = WHITE;
          hold_d  = HOLD_LOAD;
          count_d = (move_count < MOVE_MAX) ? move_count + MOVE_CNT_W'(1) : MOVE_MAX;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      timer_load   <= 1'b0;
      white_run    <= 1'b0;
      black_run    <= 1'b0;
      side_to_move <= WHITE;
      game_over    <= 1'b0;
      result       <= RES_NONE;
      move_count   <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      timer_load   <= (state_d == LOAD);
      white_run    <= (state_d == WHITE_RUN);
      black_run    <= (state_d == BLACK_RUN);
      side_to_move <= side_d;
      game_over    <= (state_d == GAME_OVER);
      result       <= result_d;
      move_count   <= count_d;
    end
  end

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Self-checking bench for chess_clock_ctrl: directed scenarios plus random
// play compared against a game-level reference model.
module tb_chess_clock_ctrl;
  import chess_clock_ctrl_pkg::*;

  localparam int H    = 4;
  localparam int MAXM = 999;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic game_start = 1'b0, move_done = 1'b0, resign = 1'b0;
  logic white_time_up = 1'b0, black_time_up = 1'b0;
  logic timer_load, white_run, black_run, game_over;
  player_t side_to_move;
  result_t result;
  logic [9:0] move_count;

  chess_clock_ctrl #(.MOVE_HOLDOFF(H), .MAX_MOVES(MAXM)) dut (
    .clk(clk), .reset_n(reset_n), .game_start(game_start), .move_done(move_done),
    .resign(resign), .white_time_up(white_time_up), .black_time_up(black_time_up),
    .timer_load(timer_load), .white_run(white_run), .black_run(black_run),
    .side_to_move(side_to_move), .game_over(game_over), .result(result),
    .move_count(move_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  // Reference model: game phase 0 idle, 1 loading, 2 arming, 3 playing, 4 finished.
  int m_phase, m_count, m_result, m_block_until;
  bit m_white, m_load;

  task automatic model_reset();
    m_phase = 0; m_count = 0; m_result = 0; m_white = 1'b1; m_load = 1'b0;
    m_block_until = 0;
  endtask

  task automatic model_step(input bit gs, md, rs, wtu, btu);
    bit flag;
    m_load = 1'b0;
    case (m_phase)
      0, 4: if (gs) begin
        m_phase = 1; m_load = 1'b1; m_count = 0; m_result = 0; m_white = 1'b1;
      end
      1: m_phase = 2;
      2: m_phase = 3;
      3: begin
        flag = m_white ? wtu : btu;
        if (flag || rs) begin
          m_phase = 4;
          m_result = m_white ? 2 : 1;
        end else if (md && cyc >= m_block_until) begin
          m_block_until = cyc + H + 1;
          if (!m_white) m_count = (m_count < MAXM) ? m_count + 1 : MAXM;
          m_white = !m_white;
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  function automatic logic [16:0] exp_vec();
    logic [31:0] r, c;
    r = m_result;
    c = m_count;
    return {m_load, (m_phase == 3) && m_white, (m_phase == 3) && !m_white,
            !m_white, m_phase == 4, r[1:0], c[9:0]};
  endfunction

  function automatic logic [16:0] act_vec();
    return {timer_load, white_run, black_run, side_to_move, game_over, result, move_count};
  endfunction

  // One clock of stimulus; outputs are stable 1 time unit after the edge on return.
  task automatic tick(input bit gs, md, rs, wtu, btu);
    game_start = gs; move_done = md; resign = rs;
    white_time_up = wtu; black_time_up = btu;
    @(posedge clk);
    model_step(gs, md, rs, wtu, btu);
    cyc++;
    #1;
    game_start = 0; move_done = 0; resign = 0; white_time_up = 0; black_time_up = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic new_game();
    pulse_reset();
    tick(1, 0, 0, 0, 0);
    idle(2);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (act_vec() !== 17'd0) $display("FAIL reset_vals: got %h want 00000", act_vec());
    else n_pass++;
    reset_n = 1'b1;
    cyc = 0;
    // Moves, resigns and flags in IDLE must not disturb anything.
    tick(0, 1, 1, 1, 1);
    n_checks++;
    if (act_vec() !== 17'd0) $display("FAIL idle_ignore: got %h want 00000", act_vec());
    else n_pass++;
    cyc = 0;
  endtask

  task automatic test_start();
    idle(10);
    n_checks++;
    if (timer_load !== 1'b0) $display("FAIL pre_load: got %b want 0", timer_load);
    else n_pass++;
    tick(1, 0, 0, 0, 0);  // game_start at cycle 10
    n_checks++;
    if ({timer_load, white_run, side_to_move} !== {1'b1, 1'b0, WHITE})
      $display("FAIL load_c11: got %b want 100", {timer_load, white_run, side_to_move});
    else n_pass++;
    tick(1, 0, 0, 0, 0);  // second game_start during LOAD is ignored
    n_checks++;
    if ({timer_load, white_run} !== 2'b00)
      $display("FAIL arm_c12: got %b want 00", {timer_load, white_run});
    else n_pass++;
    tick(0, 0, 0, 0, 0);
    n_checks++;
    if ({timer_load, white_run, black_run, side_to_move} !== {3'b010, WHITE})
      $display("FAIL run_c13: got %b want 0100",
               {timer_load, white_run, black_run, side_to_move});
    else n_pass++;
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, 0, 0, 0);
      n_checks++;
      if ({white_run, black_run} !== ((i % 2 == 0) ? 2'b01 : 2'b10))
        $display("FAIL alt_%0d: got %b want %b", i, {white_run, black_run},
                 (i % 2 == 0) ? 2'b01 : 2'b10);
      else n_pass++;
      idle(9);
    end
    n_checks++;
    if ({move_count, side_to_move} !== {10'd3, WHITE})
      $display("FAIL alt_end: got count %0d side %0d want 3 0", move_count, side_to_move);
    else n_pass++;
  endtask

  task automatic test_holdoff();
    new_game();
    tick(0, 1, 0, 0, 0);  // accepted at c
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);  // c+2: inside holdoff
    n_checks++;
    if ({side_to_move, move_count} !== {BLACK, 10'd0})
      $display("FAIL hold_c2: got side %0d count %0d want 1 0", side_to_move, move_count);
    else n_pass++;
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);  // c+4: last blocked cycle
    n_checks++;
    if (side_to_move !== BLACK) $display("FAIL hold_c4: got %0d want 1", side_to_move);
    else n_pass++;
    tick(0, 1, 0, 0, 0);  // c+5: holdoff expired
    n_checks++;
    if ({side_to_move, move_count, white_run} !== {WHITE, 10'd1, 1'b1})
      $display("FAIL hold_c5: got side %0d count %0d wrun %b want 0 1 1",
               side_to_move, move_count, white_run);
    else n_pass++;
  endtask

  task automatic test_flag_collision();
    new_game();
    tick(0, 1, 0, 0, 0); idle(5);
    tick(0, 1, 0, 0, 0); idle(5);  // count 1
    tick(0, 1, 0, 0, 0); idle(5);  // black to move
    tick(0, 1, 0, 0, 1);           // flag and move together
    n_checks++;
    if ({game_over, result, move_count, white_run, black_run} !==
        {1'b1, RES_WHITE_WINS, 10'd1, 2'b00})
      $display("FAIL flag_coll: got over %b res %0d count %0d run %b%b want 1 1 1 00",
               game_over, result, move_count, white_run, black_run);
    else n_pass++;
  endtask

  task automatic test_ignore();
    pulse_reset();
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0);  // LOAD
    tick(0, 0, 0, 1, 0);  // ARM
    n_checks++;
    if ({white_run, game_over} !== 2'b10)
      $display("FAIL arm_flag: got %b want 10", {white_run, game_over});
    else n_pass++;
    tick(0, 1, 0, 0, 0); idle(5);
    tick(0, 0, 0, 1, 0);  // white flag while black runs
    n_checks++;
    if ({black_run, game_over} !== 2'b10)
      $display("FAIL black_wflag: got %b want 10", {black_run, game_over});
    else n_pass++;
    tick(0, 0, 1, 0, 0);
    n_checks++;
    if ({game_over, result, white_run, black_run} !== {1'b1, RES_WHITE_WINS, 2'b00})
      $display("FAIL resign_b: got over %b res %0d run %b%b want 1 1 00",
               game_over, result, white_run, black_run);
    else n_pass++;
    tick(0, 1, 1, 1, 1);  // all ignored once over
    n_checks++;
    if ({game_over, result, move_count} !== {1'b1, RES_WHITE_WINS, 10'd0})
      $display("FAIL over_hold: got over %b res %0d count %0d want 1 1 0",
               game_over, result, move_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    new_game();
    for (int i = 0; i < 10; i++) begin
      tick(0, 1, 0, 0, 0);
      idle(5);
    end
    n_checks++;
    if (move_count !== 10'd5) $display("FAIL mid_count: got %0d want 5", move_count);
    else n_pass++;
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (act_vec() !== 17'd0) $display("FAIL async_rst: got %h want 00000", act_vec());
    else n_pass++;
    #1;
    reset_n = 1'b1;
    model_reset();
    tick(1, 0, 0, 0, 0);
    n_checks++;
    if ({timer_load, white_run, move_count} !== {2'b10, 10'd0})
      $display("FAIL restart_load: got %b want 100", {timer_load, white_run, move_count});
    else n_pass++;
    idle(2);
    n_checks++;
    if ({timer_load, white_run, side_to_move} !== {2'b01, WHITE})
      $display("FAIL restart_run: got %b want 010", {timer_load, white_run, side_to_move});
    else n_pass++;
  endtask

  task automatic test_saturation();
    new_game();
    for (int i = 0; i < 2000; i++) begin
      tick(0, 1, 0, 0, 0);
      idle(5);
      if (i == 1997) begin
        n_checks++;
        if (move_count !== 10'd999) $display("FAIL sat_reach: got %0d want 999", move_count);
        else n_pass++;
      end
    end
    n_checks++;
    if (move_count !== 10'd999) $display("FAIL sat_hold: got %0d want 999", move_count);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int g = 0; g < 6; g++) begin
      new_game();
      for (int i = 0; i < 400; i++) begin
        tick($urandom_range(49) == 0, $urandom_range(2) == 0, $urandom_range(149) == 0,
             $urandom_range(99) == 0, $urandom_range(99) == 0);
        n_checks++;
        if (act_vec() !== exp_vec())
          $display("FAIL rand_g%0d_c%0d: got %h want %h", g, i, act_vec(), exp_vec());
        else n_pass++;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start();
    test_alternate();
    test_holdoff();
    test_flag_collision();
    test_ignore();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
